// File: rtl/branch_target_pkg.sv
// Shared types and the default branch-target table loaded by the init sequencer.
package branch_target_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_COUNT = 10;

    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_TABLE [DEFAULT_COUNT] = '{
        10'd0, 10'd10, 10'd43, 10'd104, 10'd77, 10'd92, 10'd84, 10'd101, 10'd1, 10'd19
    };

    // Indices past the table read as zero so the caller can sweep the whole depth.
    function automatic logic [DEFAULT_WIDTH-1:0] default_entry(input int idx);
        logic [DEFAULT_WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < DEFAULT_COUNT; k++) begin
            if (k == idx) v = DEFAULT_TABLE[k];
        end
        return v;
    endfunction

endpackage

// File: rtl/btt_regfile.sv
// Target storage: DEPTH entries of {valid, value}, one write port, one combinational read port.
module btt_regfile #(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic         wvalid,
    input  logic [A-1:0] raddr,
    output logic [D-1:0] rdata,
    output logic         rvalid
);
    localparam int DEPTH = 2**A;

    logic [DEPTH-1:0] valid_q;
    logic [D-1:0]     mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[waddr] <= wvalid;
        end
    end

    // Value bits only change on a validating write; invalidation touches the valid bit alone.
    always_ff @(posedge clk) begin
        if (we && wvalid) mem[waddr] <= wdata;
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid_q[raddr];

endmodule

// File: rtl/branch_target_table.sv
// Branch-target lookup: init sequencer, write/invalidate port, bypassed read and target resolve.
module branch_target_table
    import branch_target_pkg::*;
#(
    parameter int D    = 10,
    parameter int A    = 4,
    parameter int NDEF = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         inv_en,
    input  logic         rd_en,
    input  logic [A-1:0] rd_addr,
    input  logic         rd_rel,
    input  logic [D-1:0] pc_in,
    output logic         busy,
    output logic [D-1:0] target,
    output logic         target_vld,
    output logic         hit
);
    localparam int DEPTH = 2**A;

    state_t       state;
    logic [A-1:0] init_cnt;

    logic         we;
    logic [A-1:0] waddr;
    logic [D-1:0] wdata;
    logic         wvalid;
    logic [D-1:0] rf_data;
    logic         rf_valid;

    logic [D-1:0] ent_val;
    logic         ent_hit;
    logic [D-1:0] resolved;

    btt_regfile #(.D(D), .A(A)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .wvalid (wvalid),
        .raddr  (rd_addr),
        .rdata  (rf_data),
        .rvalid (rf_valid)
    );

    // During INIT the sequencer owns the write port; afterwards wr_en beats inv_en.
    always_comb begin
        we     = 1'b0;
        waddr  = wr_addr;
        wdata  = wr_data;
        wvalid = 1'b1;
        if (state == INIT) begin
            we     = 1'b1;
            waddr  = init_cnt;
            wdata  = D'(default_entry(int'(init_cnt)));
            wvalid = (int'(init_cnt) < NDEF);
        end else if (wr_en) begin
            we = 1'b1;
        end else if (inv_en) begin
            we     = 1'b1;
            wvalid = 1'b0;
        end
    end

    // A same-cycle write or invalidate of the read index is visible to that read.
    always_comb begin
        ent_val = rf_data;
        ent_hit = rf_valid;
        if (wr_en && wr_addr == rd_addr) begin
            ent_val = wr_data;
            ent_hit = 1'b1;
        end else if (inv_en && wr_addr == rd_addr) begin
            ent_hit = 1'b0;
        end
        if (!ent_hit)    resolved = pc_in + D'(1);
        else if (rd_rel) resolved = pc_in + ent_val;
        else             resolved = ent_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            busy       <= 1'b1;
            target     <= '0;
            target_vld <= 1'b0;
            hit        <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    target_vld <= 1'b0;
                    init_cnt   <= init_cnt + A'(1);
                    if (init_cnt == A'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    target_vld <= rd_en;
                    if (rd_en) begin
                        target <= resolved;
                        hit    <= ent_hit;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table against an array-based reference model.
module tb_branch_target_table;
    localparam int D     = 10;
    localparam int A     = 4;
    localparam int DEPTH = 16;
    localparam int MOD   = 1024;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         inv_en;
    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic         rd_rel;
    logic [D-1:0] pc_in;
    logic         busy;
    logic [D-1:0] target;
    logic         target_vld;
    logic         hit;

    branch_target_table #(.D(D), .A(A), .NDEF(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .inv_en     (inv_en),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_rel     (rd_rel),
        .pc_in      (pc_in),
        .busy       (busy),
        .target     (target),
        .target_vld (target_vld),
        .hit        (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int ref_val [DEPTH];
    bit ref_vld [DEPTH];
    int exp_target;
    bit exp_hit;
    int defaults [10] = '{0, 10, 43, 104, 77, 92, 84, 101, 1, 19};

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ref_vld[i] = (i < 10);
            ref_val[i] = (i < 10) ? defaults[i] : 0;
        end
        exp_target = 0;
        exp_hit    = 0;
    endtask

    task automatic drive_idle();
        wr_en = 0; wr_addr = '0; wr_data = '0; inv_en = 0;
        rd_en = 0; rd_addr = '0; rd_rel = 0; pc_in = '0;
    endtask

    // One clock of stimulus; expected read result comes from the table model plus bypass rules.
    task automatic op(input bit we, input int wa, input int wd, input bit ie,
                      input bit re, input int ra, input bit rel, input int pc, input string tag);
        int v;
        bit h;
        wr_en = we; wr_addr = A'(wa); wr_data = D'(wd); inv_en = ie;
        rd_en = re; rd_addr = A'(ra); rd_rel = rel; pc_in = D'(pc);
        if (re) begin
            h = ref_vld[ra];
            v = ref_val[ra];
            if (we && wa == ra) begin h = 1; v = wd; end
            else if (ie && wa == ra) h = 0;
            if (!h)       exp_target = (pc + 1) % MOD;
            else if (rel) exp_target = (pc + v) % MOD;
            else          exp_target = v;
            exp_hit = h;
        end
        if (we) begin ref_vld[wa] = 1; ref_val[wa] = wd; end
        else if (ie) ref_vld[wa] = 0;
        @(posedge clk); #1;
        check({tag, ".vld"}, int'(target_vld), int'(re));
        check({tag, ".target"}, int'(target), exp_target);
        check({tag, ".hit"}, int'(hit), int'(exp_hit));
    endtask

    // Counts posedges until busy drops; bounded so a stuck init cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".busy"}, int'(busy), 1);
        check({tag, ".target"}, int'(target), 0);
        check({tag, ".vld"}, int'(target_vld), 0);
        check({tag, ".hit"}, int'(hit), 0);
    endtask

    initial begin
        int n;
        int wa, ra;
        total = 0;
        bad   = 0;
        drive_idle();
        rst_n = 0;
        model_reset();
        #12;
        check_cleared("rst");
        @(negedge clk) rst_n = 1;

        // Writes while busy must be dropped.
        wr_en = 1; wr_addr = 0; wr_data = 10'd555;
        count_busy(n);
        drive_idle();
        check("init.busy_cycles", n, 16);

        op(0, 0, 0, 0, 1, 0, 0, 77, "busy_write_dropped");
        op(0, 0, 0, 0, 1, 3, 0, 0, "abs3");
        op(0, 0, 0, 0, 1, 12, 0, 50, "miss12");
        op(0, 0, 0, 0, 0, 0, 0, 0, "hold");
        op(0, 0, 0, 0, 1, 12, 0, 1023, "miss_wrap");
        op(0, 0, 0, 0, 1, 2, 1, 4, "rel2");
        op(1, 5, 1023, 0, 0, 0, 0, 0, "wr5_neg1");
        op(0, 0, 0, 0, 1, 5, 1, 4, "rel5_neg1");
        op(1, 5, 20, 0, 0, 0, 0, 0, "wr5_20");
        op(0, 0, 0, 0, 1, 5, 1, 1020, "rel5_wrap");
        op(1, 7, 300, 0, 1, 7, 0, 9, "bypass_wr7");
        op(0, 7, 0, 1, 1, 7, 0, 9, "bypass_inv7");
        op(0, 0, 0, 0, 1, 7, 0, 200, "after_inv7");
        op(1, 8, 640, 1, 1, 8, 0, 3, "wr_beats_inv");
        op(0, 0, 0, 0, 1, 8, 1, 500, "rel8_after");

        for (int i = 0; i < 400; i++) begin
            ra = $urandom_range(0, DEPTH - 1);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, DEPTH - 1);
            op($urandom_range(0, 3) == 0, wa, $urandom_range(0, MOD - 1),
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7, ra,
               $urandom_range(0, 1) == 1, $urandom_range(0, MOD - 1), "rand");
        end

        // Reset during an outstanding read clears outputs without a clock edge.
        op(0, 0, 0, 0, 1, 3, 0, 0, "pre_reset");
        #3 rst_n = 0;
        drive_idle();
        #1;
        check_cleared("rst_mid_read");
        model_reset();
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        check("init6.busy", int'(busy), 1);
        rst_n = 0;
        #1;
        check_cleared("rst_mid_init");
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        #1;
        count_busy(n);
        check("reinit.busy_cycles", n, 16);

        for (int i = 0; i < DEPTH; i++) begin
            op(0, 0, 0, 0, 1, i, 0, $urandom_range(0, MOD - 1), "reinit_table");
        end
        for (int i = 0; i < 10; i++) begin
            op(0, 0, 0, 0, 1, i, 0, 0, "b2b");
        end
        op(0, 0, 0, 0, 0, 0, 0, 0, "b2b_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
